// File: rtl/demux_pkg.sv
// Shared definitions for the demux frame sequencer and related scan blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package demux_pkg;

  // Number of demux output channels and the width of the select bus.
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  // Sequencer state encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRIVE = 2'd2
  } state_t;

  // True when ch addresses the final demux channel.
  function automatic logic is_last_ch(input logic [SEL_W-1:0] ch);
    return ch == SEL_W'(NUM_CH - 1);
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Loadable down-counter with a zero flag, used to time per-channel dwell windows.
// Latency: load/decrement take effect on the next rising edge; zero is combinational from count.
// Backpressure: none; enable simply stalls the count, and the count saturates at zero.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   load         load load_value on the next edge (wins over enable)
//   load_value   value to load
//   enable       decrement by one on the next edge when count is non-zero
//   count        current count
//   zero         count == 0
module dwell_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      // Saturating at zero keeps a stray enable from wrapping to all-ones.
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/demux_frame_sequencer.sv
// Steps a 1-to-4 demux through channels 0..3, driving A with one frame bit per channel
// for DWELL cycles after a one-cycle select-setup slot; a frame is 4*(1+DWELL) cycles.
// Backpressure: in_ready is high only in IDLE; a new word may be taken on the frame_done cycle.
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   in_valid      frame word offered
//   in_data[3:0]  frame word; bit k is driven onto A while channel k is selected
//   in_ready      sequencer idle and able to accept a word (combinational)
//   abort         synchronous frame termination, ignored while idle
//   A             demux data input (registered)
//   S1, S0        demux select MSB/LSB (registered)
//   busy          frame in progress (registered)
//   frame_done    one-cycle pulse after a frame that completed without abort (registered)
//
// All registered outputs are loaded with the values that belong to the state being
// entered, so each cycle's outputs describe that cycle's state. The select lines only
// change on entry to SETUP, and A is forced low on that same edge; this yields the
// break-before-make gap with no combinational path to the pins.
module demux_frame_sequencer
  import demux_pkg::*;
#(
  parameter int DWELL = 4,  // drive cycles per channel, 1..255
  parameter int CNT_W = 8   // dwell counter width, 2**CNT_W > DWELL
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  input  logic       abort,
  output logic       A,
  output logic       S0,
  output logic       S1,
  output logic       busy,
  output logic       frame_done
);

  state_t                state, state_nxt;
  logic [NUM_CH-1:0]     word, word_nxt;
  logic [SEL_W-1:0]      ch, ch_nxt;
  logic [SEL_W-1:0]      sel_nxt;
  logic                  a_nxt;
  logic                  busy_nxt;
  logic                  done_nxt;

  logic                  cnt_load;
  logic                  cnt_en;
  logic [CNT_W-1:0]      cnt;
  logic                  cnt_zero;

  logic                  accept;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  // Dwell timer: loaded with DWELL-1 on entry to DRIVE, so DRIVE lasts DWELL cycles
  // ending on the cycle where the count reads zero.
  dwell_counter #(
    .W (CNT_W)
  ) u_dwell (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (cnt_load),
    .load_value (CNT_W'(DWELL - 1)),
    .enable     (cnt_en),
    .count      (cnt),
    .zero       (cnt_zero)
  );

  always_comb begin
    state_nxt = state;
    word_nxt  = word;
    ch_nxt    = ch;
    sel_nxt   = {S1, S0};
    a_nxt     = 1'b0;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;

    if (abort && (state != IDLE)) begin
      // Abort beats every other transition; selects hold so A low is the only change.
      state_nxt = IDLE;
      busy_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy_nxt = 1'b0;
          if (accept) begin
            word_nxt  = in_data;
            ch_nxt    = '0;
            sel_nxt   = '0;
            busy_nxt  = 1'b1;
            state_nxt = SETUP;
          end
        end

        SETUP: begin
          // Select lines settled during this cycle; A may now follow the frame bit.
          state_nxt = DRIVE;
          cnt_load  = 1'b1;
          a_nxt     = word[ch];
        end

        DRIVE: begin
          if (!cnt_zero) begin
            cnt_en = 1'b1;
            a_nxt  = word[ch];
          end else if (!is_last_ch(ch)) begin
            // Move to the next channel: new select with A already low.
            ch_nxt    = ch + SEL_W'(1);
            sel_nxt   = ch + SEL_W'(1);
            state_nxt = SETUP;
          end else begin
            // Channel 3 exit takes precedence, so ch never wraps.
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end
        end

        default: begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      word       <= '0;
      ch         <= '0;
      A          <= 1'b0;
      S1         <= 1'b0;
      S0         <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      word       <= word_nxt;
      ch         <= ch_nxt;
      A          <= a_nxt;
      S1         <= sel_nxt[1];
      S0         <= sel_nxt[0];
      busy       <= busy_nxt;
      frame_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_demux_frame_sequencer.sv
// Bench for demux_frame_sequencer: DWELL=4 and DWELL=1 instances, directed scenarios
// followed by random traffic, each cycle compared against a per-frame trace model.
module tb_demux_frame_sequencer;

  typedef struct packed {
    logic [1:0] sel;
    logic       a;
    logic       busy;
    logic       done;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vld [2];
  logic [3:0] dat [2];
  logic       abt [2];
  logic       rdy [2];
  logic       a   [2];
  logic       s0  [2];
  logic       s1  [2];
  logic       bsy [2];
  logic       done[2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int DW = (g == 0) ? 4 : 1;

    demux_frame_sequencer #(
      .DWELL (DW),
      .CNT_W (8)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (vld[g]),
      .in_data    (dat[g]),
      .in_ready   (rdy[g]),
      .abort      (abt[g]),
      .A          (a[g]),
      .S0         (s0[g]),
      .S1         (s1[g]),
      .busy       (bsy[g]),
      .frame_done (done[g])
    );

    // Reference: an accepted word expands into the full list of per-cycle outputs
    // (per channel: one select slot with A low, then DW cycles of the channel bit),
    // followed by the frame_done cycle. Idle cycles hold the last select.
    obs_t       trace[$];
    obs_t       exp_o = '0;
    logic [1:0] prev_sel = 2'b00;

    always @(posedge clk or negedge rst_n) begin
      obs_t e;
      if (!rst_n) begin
        trace.delete();
        exp_o = '0;
      end else if (trace.size() != 0) begin
        if (abt[g]) begin
          trace.delete();
          exp_o = '{sel: exp_o.sel, a: 1'b0, busy: 1'b0, done: 1'b0};
        end else begin
          exp_o = trace.pop_front();
        end
      end else if (vld[g]) begin
        for (int c = 0; c < 4; c++) begin
          e = '{sel: 2'(c), a: 1'b0, busy: 1'b1, done: 1'b0};
          trace.push_back(e);
          for (int k = 0; k < DW; k++) begin
            e = '{sel: 2'(c), a: dat[g][c], busy: 1'b1, done: 1'b0};
            trace.push_back(e);
          end
        end
        e = '{sel: 2'd3, a: 1'b0, busy: 1'b0, done: 1'b1};
        trace.push_back(e);
        exp_o = trace.pop_front();
      end else begin
        exp_o = '{sel: exp_o.sel, a: 1'b0, busy: 1'b0, done: 1'b0};
      end
    end

    always @(negedge clk) begin
      if (rst_n) begin
        check($sformatf("d%0d_sel", DW), {s1[g], s0[g]}, exp_o.sel);
        check($sformatf("d%0d_a", DW), a[g], exp_o.a);
        check($sformatf("d%0d_busy", DW), bsy[g], exp_o.busy);
        check($sformatf("d%0d_done", DW), done[g], exp_o.done);
        check($sformatf("d%0d_ready", DW), rdy[g], trace.size() == 0);
        // Break-before-make: A must be low in any cycle whose select just changed.
        check($sformatf("d%0d_glitch", DW), ({s1[g], s0[g]} != prev_sel) && a[g], 1'b0);
        prev_sel = {s1[g], s0[g]};
      end
    end
  end

  // Offers one word to instance g (which must be idle), then watches up to 40 cycles.
  // Cycle 0 is the cycle right after the accept edge. in_data is scrambled after the
  // accept edge; abort is raised in cycle abort_cyc so it acts on that cycle's end edge.
  task automatic run_frame(input int g, input logic [3:0] w, input int abort_cyc,
                           output int cyc, output logic [31:0] a_bits,
                           output logic [63:0] sel_bits, output logic [2:0] post);
    @(negedge clk);
    vld[g] = 1'b1;
    dat[g] = w;
    @(posedge clk);
    cyc      = -1;
    a_bits   = '0;
    sel_bits = '0;
    post     = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done[g]) begin
        cyc = c;
        break;
      end
      if (c < 32) begin
        a_bits[c]        = a[g];
        sel_bits[2*c +: 2] = {s1[g], s0[g]};
      end
      if (c == abort_cyc + 1) post = {a[g], bsy[g], rdy[g]};
      vld[g] = 1'b0;
      dat[g] = 4'($urandom);
      abt[g] = (c == abort_cyc);
    end
    abt[g] = 1'b0;
    vld[g] = 1'b0;
  endtask

  initial begin
    int          cyc;
    logic [31:0] a_bits, exp_a;
    logic [63:0] sel_bits, exp_sel;
    logic [2:0]  post;
    logic [3:0]  w;
    logic [7:0]  pat1;

    for (int g = 0; g < 2; g++) begin
      vld[g] = 1'b0;
      dat[g] = 4'h0;
      abt[g] = 1'b0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_a", a[0], 1'b0);
    check("rst_sel", {s1[0], s0[0]}, 2'b00);
    check("rst_busy", bsy[0], 1'b0);
    check("rst_ready", rdy[0], 1'b1);
    check("rst_done", done[0], 1'b0);
    repeat (2) @(negedge clk);

    // Single frame, DWELL=4, word 1010
    w = 4'b1010;
    run_frame(0, w, -1, cyc, a_bits, sel_bits, post);
    exp_a   = '0;
    exp_sel = '0;
    for (int c = 0; c < 20; c++) begin
      exp_a[c]          = ((c % 5) != 0) && w[c / 5];
      exp_sel[2*c +: 2] = 2'(c / 5);
    end
    check("single_done_cycle", cyc, 20);
    check("single_a_pattern", a_bits, exp_a);
    check("single_sel_pattern", sel_bits, exp_sel);
    check("single_busy_at_done", bsy[0], 1'b0);

    // Back-to-back: F then 0 with in_valid held high
    @(negedge clk);
    vld[0] = 1'b1;
    dat[0] = 4'hF;
    @(posedge clk);
    cyc = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      dat[0] = 4'h0;
      if (done[0]) begin
        cyc = c;
        break;
      end
    end
    check("b2b_first_done", cyc, 20);
    check("b2b_ready_on_done", rdy[0], 1'b1);
    @(negedge clk);
    vld[0] = 1'b0;
    check("b2b_no_gap_busy", bsy[0], 1'b1);
    cyc = -1;
    a_bits = '0;
    for (int c = 1; c < 40; c++) begin
      @(negedge clk);
      if (done[0]) begin
        cyc = c;
        break;
      end
      a_bits[c] = a[0];
    end
    check("b2b_second_done", cyc, 20);
    check("b2b_second_a_zero", a_bits, 32'h0);

    // Abort in the channel-2 DRIVE window
    run_frame(0, 4'hF, 11, cyc, a_bits, sel_bits, post);
    check("abort_a_before", a_bits[11], 1'b1);
    check("abort_no_done", cyc, -1);
    check("abort_post_a_busy_ready", post, 3'b001);

    // Async reset during channel-3 DRIVE
    @(negedge clk);
    vld[0] = 1'b1;
    dat[0] = 4'hF;
    @(posedge clk);
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      vld[0] = 1'b0;
    end
    check("arst_pre_a", a[0], 1'b1);
    check("arst_pre_sel", {s1[0], s0[0]}, 2'b11);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_a", a[0], 1'b0);
    check("arst_sel", {s1[0], s0[0]}, 2'b00);
    check("arst_busy", bsy[0], 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    w = 4'b0101;
    run_frame(0, w, -1, cyc, a_bits, sel_bits, post);
    exp_a = '0;
    for (int c = 0; c < 20; c++) exp_a[c] = ((c % 5) != 0) && w[c / 5];
    check("arst_restart_done", cyc, 20);
    check("arst_restart_a", a_bits, exp_a);

    // DWELL=1: word 0110 gives A = 0,0,0,1,0,1,0,0
    pat1 = 8'b0010_1000;
    run_frame(1, 4'b0110, -1, cyc, a_bits, sel_bits, post);
    check("d1_done_cycle", cyc, 8);
    check("d1_a_pattern", a_bits[7:0], pat1);

    // Random traffic on both instances, checked cycle by cycle against the model
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        vld[g] = ($urandom_range(0, 3) != 0);
        dat[g] = 4'($urandom);
        abt[g] = ($urandom_range(0, 23) == 0);
      end
    end
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      vld[g] = 1'b0;
      abt[g] = 1'b0;
    end
    repeat (30) @(negedge clk);
    check("drain_idle0", rdy[0], 1'b1);
    check("drain_idle1", rdy[1], 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
